// File: rtl/game_key_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Package : game_key_pkg
// Keycode constants, FSM state/class enums and the code-class helpers shared
// by the key conditioner and its stability filter.
// Rev 1.0 : initial release
// ============================================================================
package game_key_pkg;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_FIRE  = 8'h2c;
    localparam logic [7:0] KEY_START = 8'h28;
    localparam logic [7:0] KEY_LVL1  = 8'h1e;
    localparam logic [7:0] KEY_LVL2  = 8'h1f;
    localparam logic [7:0] KEY_LVL3  = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_PULSE   = 2'd2,
        ST_LOCKOUT = 2'd3
    } key_state_e;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_HELD  = 2'd1,
        CLS_PULSE = 2'd2
    } key_class_e;

    function automatic key_class_e key_class(input logic [7:0] code);
        case (code)
            KEY_LEFT, KEY_RIGHT:                           return CLS_HELD;
            KEY_FIRE, KEY_START, KEY_LVL1, KEY_LVL2, KEY_LVL3: return CLS_PULSE;
            default:                                       return CLS_NONE;
        endcase
    endfunction

    // Level selected by a level key; 0 means "not a level key".
    function automatic logic [1:0] level_of(input logic [7:0] code);
        case (code)
            KEY_LVL1: return 2'd1;
            KEY_LVL2: return 2'd2;
            KEY_LVL3: return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_key_conditioner_if.sv
`default_nettype none
// ============================================================================
// Interface : game_key_conditioner_if
// Host keycode input and conditioned key outputs of the key conditioner.
// Rev 1.0 : initial release
// ============================================================================
interface game_key_conditioner_if;
    logic [7:0] keycode_in;
    logic       keycode_valid;
    logic [7:0] key;
    logic       key_event;
    logic [1:0] level;
    logic [7:0] held_frames;

    modport master (
        output keycode_in, keycode_valid,
        input  key, key_event, level, held_frames
    );

    modport slave (
        input  keycode_in, keycode_valid,
        output key, key_event, level, held_frames
    );
endinterface
`default_nettype wire

// File: rtl/game_key_conditioner_filter.sv
`default_nettype none
// ============================================================================
// Module : keycode_stability_filter
// Accepts a keycode only after STABLE_FRAMES identical consecutive samples.
// Rev 1.0 : initial release
// ============================================================================
module keycode_stability_filter
    import game_key_pkg::*;
#(
    parameter int STABLE_FRAMES = 2
) (
    input  wire        frame_clk,
    input  wire        Reset,
    input  wire  [7:0] keycode_i,
    input  wire        keycode_valid_i,
    output logic [7:0] accepted_o,
    output logic       change_o
);

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_FRAMES);

    logic [7:0] sample;
    logic [7:0] cand_q, cand_d;
    logic [3:0] count_q, count_d;
    logic [7:0] acc_q;

    assign sample = keycode_valid_i ? keycode_i : KEY_NONE;

    always_comb begin
        cand_d  = cand_q;
        count_d = count_q;
        if (sample == cand_q) begin
            if (count_q != STABLE_CNT) begin
                count_d = count_q + 4'd1;
            end
        end else begin
            cand_d  = sample;
            count_d = 4'd1;
        end
    end

    // Accepted code is visible the cycle after the count saturates so the
    // conditioner can register it on the following edge.
    assign accepted_o = (count_q == STABLE_CNT) ? cand_q : acc_q;
    assign change_o   = (accepted_o != acc_q);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            cand_q  <= KEY_NONE;
            count_q <= 4'd0;
            acc_q   <= KEY_NONE;
        end else begin
            cand_q  <= cand_d;
            count_q <= count_d;
            acc_q   <= accepted_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module : game_key_conditioner
// Debounces host keycodes and turns them into held/pulse key events, level
// selection and hold-time count. KEY_AUTOREPEAT_EN enables fire auto-repeat.
// Rev 1.0 : initial release
// ============================================================================
module game_key_conditioner
    import game_key_pkg::*;
#(
    parameter int STABLE_FRAMES = 2,
    parameter int REPEAT_FRAMES = 30
) (
    input  wire                   frame_clk,
    input  wire                   Reset,
    game_key_conditioner_if.slave bus
);

    if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15 || REPEAT_FRAMES < 2) begin : g_bad_param
        $error("game_key_conditioner: parameter out of range");
    end

    logic [7:0] accepted;
    logic       acc_change;
    key_class_e acc_class;
    logic [1:0] acc_level;

    key_state_e state_q, state_d;
    logic [7:0] key_q, key_d;
    logic       key_event_q, key_event_d;
    logic [1:0] level_q, level_d;
    logic [7:0] held_q, held_d;
    logic [7:0] lock_q, lock_d;

    keycode_stability_filter #(
        .STABLE_FRAMES (STABLE_FRAMES)
    ) u_filter (
        .frame_clk       (frame_clk),
        .Reset           (Reset),
        .keycode_i       (bus.keycode_in),
        .keycode_valid_i (bus.keycode_valid),
        .accepted_o      (accepted),
        .change_o        (acc_change)
    );

    assign acc_class = key_class(accepted);
    assign acc_level = level_of(accepted);

`ifdef KEY_AUTOREPEAT_EN
    localparam int               RPT_W    = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_FRAMES - 1);
    logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (acc_class == CLS_HELD)       state_d = ST_HOLD;
                else if (acc_class == CLS_PULSE) state_d = ST_PULSE;
                else                             state_d = ST_IDLE;
            end
            ST_PULSE: state_d = ST_LOCKOUT;
            ST_LOCKOUT: begin
                if (accepted == lock_q) begin
                    state_d = ST_LOCKOUT;
`ifdef KEY_AUTOREPEAT_EN
                    if (lock_q == KEY_FIRE && rpt_q == RPT_LAST) state_d = ST_PULSE;
`endif
                end else if (acc_class == CLS_HELD)  state_d = ST_HOLD;
                else if (acc_class == CLS_PULSE)     state_d = ST_PULSE;
                else                                 state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_PULSE) lock_d = accepted;

        // Outputs follow the next state so key changes on the transition edge.
        key_d       = (state_d == ST_HOLD || state_d == ST_PULSE) ? accepted : KEY_NONE;
        key_event_d = (state_d == ST_PULSE);
        level_d     = level_q;
        if (state_d == ST_PULSE && acc_level != 2'd0) level_d = acc_level;

        if (acc_change)            held_d = 8'd0;
        else if (held_q == 8'hff)  held_d = held_q;
        else                       held_d = held_q + 8'd1;
    end

`ifdef KEY_AUTOREPEAT_EN
    // Counter holds frames elapsed since the last fire pulse while locked out.
    always_comb begin
        rpt_d = '0;
        if (lock_q == KEY_FIRE && state_d == ST_LOCKOUT) begin
            if (state_q == ST_PULSE)      rpt_d = RPT_W'(1);
            else if (rpt_q != RPT_LAST)   rpt_d = rpt_q + RPT_W'(1);
            else                          rpt_d = rpt_q;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) rpt_q <= '0;
        else       rpt_q <= rpt_d;
    end
`endif

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            key_q       <= KEY_NONE;
            key_event_q <= 1'b0;
            level_q     <= 2'd1;
            held_q      <= 8'd0;
            lock_q      <= KEY_NONE;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_event_q <= key_event_d;
            level_q     <= level_d;
            held_q      <= held_d;
            lock_q      <= lock_d;
        end
    end

    assign bus.key         = key_q;
    assign bus.key_event   = key_event_q;
    assign bus.level       = level_q;
    assign bus.held_frames = held_q;

endmodule
`default_nettype wire

// File: tb/tb_game_key_conditioner.sv
`default_nettype none
// ============================================================================
// Testbench : tb_game_key_conditioner
// Directed frame vectors with hand-computed expectations, scoreboard-checked.
// Rev 1.0 : initial release
// ============================================================================
module tb_game_key_conditioner;

`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    typedef struct {
        logic [7:0] key;
        logic       ev;
        logic [1:0] lvl;
        logic       chk_held;
        logic [7:0] held;
        int         frame;
    } exp_t;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    int   checks    = 0;
    int   errors    = 0;
    int   frame_no  = 0;
    exp_t sb[$];
    exp_t mon_e;

    game_key_conditioner_if bus ();

    game_key_conditioner #(
        .STABLE_FRAMES (2),
        .REPEAT_FRAMES (30)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string nm, input int fr, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s frame=%0d got=%h expected=%h", nm, fr, got, exp);
        end
    endtask

    // One frame: drive inputs before the edge and queue the response expected after it.
    task automatic frame(input logic rst, input logic vld, input logic [7:0] code,
                         input logic [7:0] ekey, input logic eev, input logic [1:0] elvl,
                         input logic chk, input int eheld);
        exp_t e;
        @(negedge frame_clk);
        Reset             = rst;
        bus.keycode_valid = vld;
        bus.keycode_in    = code;
        frame_no++;
        e.key      = ekey;
        e.ev       = eev;
        e.lvl      = elvl;
        e.chk_held = chk;
        e.held     = eheld[7:0];
        e.frame    = frame_no;
        sb.push_back(e);
    endtask

    always @(posedge frame_clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("key", mon_e.frame, bus.key, mon_e.key);
            check("key_event", mon_e.frame, {7'd0, bus.key_event}, {7'd0, mon_e.ev});
            check("level", mon_e.frame, {6'd0, bus.level}, {6'd0, mon_e.lvl});
            if (mon_e.chk_held) check("held_frames", mon_e.frame, bus.held_frames, mon_e.held);
        end
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout frame=%0d got=running expected=finished", frame_no);
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $finish;
    end

    initial begin
        bus.keycode_in    = 8'h00;
        bus.keycode_valid = 1'b0;

        // Reset state
        frame(1, 0, 8'h00, 8'h00, 0, 2'd1, 1, 0);
        frame(1, 0, 8'h00, 8'h00, 0, 2'd1, 1, 0);

        // Right held 10 frames: key appears on the third edge, hold count restarts there
        for (int j = 1; j <= 10; j++)
            frame(0, 1, 8'h07, (j < 3) ? 8'h00 : 8'h07, 0, 2'd1, 1, (j < 3) ? j : j - 3);
        // Release with invalid (ignored) keycode on the bus
        frame(0, 0, 8'h04, 8'h07, 0, 2'd1, 1, 8);
        frame(0, 0, 8'h04, 8'h07, 0, 2'd1, 1, 9);
        frame(0, 0, 8'h04, 8'h00, 0, 2'd1, 1, 0);

        // Fire held 40 frames: single shot (plus one repeat 30 frames later with auto-repeat)
        for (int j = 1; j <= 40; j++)
            frame(0, 1, 8'h2c, (j == 3 || (AR && j == 33)) ? 8'h2c : 8'h00,
                  (j == 3 || (AR && j == 33)), 2'd1, 1, (j < 3) ? j : j - 3);
        frame(0, 0, 8'h00, 8'h00, 0, 2'd1, 1, 38);
        frame(0, 0, 8'h00, 8'h00, 0, 2'd1, 1, 39);
        frame(0, 0, 8'h00, 8'h00, 0, 2'd1, 1, 0);

        // Level 2, then level 3, then unknown code leaves level alone
        frame(0, 1, 8'h1f, 8'h00, 0, 2'd1, 0, 0);
        frame(0, 1, 8'h1f, 8'h00, 0, 2'd1, 0, 0);
        frame(0, 1, 8'h1f, 8'h1f, 1, 2'd2, 0, 0);
        frame(0, 1, 8'h20, 8'h00, 0, 2'd2, 0, 0);
        frame(0, 1, 8'h20, 8'h00, 0, 2'd2, 0, 0);
        frame(0, 1, 8'h20, 8'h20, 1, 2'd3, 0, 0);
        for (int j = 1; j <= 4; j++) frame(0, 1, 8'h15, 8'h00, 0, 2'd3, 0, 0);
        for (int j = 1; j <= 3; j++) frame(0, 0, 8'h00, 8'h00, 0, 2'd3, 0, 0);

        // One-frame glitch of left must not be accepted; hold count keeps running
        frame(0, 1, 8'h00, 8'h00, 0, 2'd3, 1, 1);
        frame(0, 1, 8'h04, 8'h00, 0, 2'd3, 1, 2);
        frame(0, 1, 8'h00, 8'h00, 0, 2'd3, 1, 3);
        frame(0, 1, 8'h00, 8'h00, 0, 2'd3, 1, 4);
        frame(0, 1, 8'h00, 8'h00, 0, 2'd3, 1, 5);

        // Left -> right -> fire -> left: hold switch, pulse, lockout exit to hold
        frame(0, 1, 8'h04, 8'h00, 0, 2'd3, 0, 0);
        frame(0, 1, 8'h04, 8'h00, 0, 2'd3, 0, 0);
        frame(0, 1, 8'h04, 8'h04, 0, 2'd3, 0, 0);
        frame(0, 1, 8'h07, 8'h04, 0, 2'd3, 0, 0);
        frame(0, 1, 8'h07, 8'h04, 0, 2'd3, 0, 0);
        frame(0, 1, 8'h07, 8'h07, 0, 2'd3, 0, 0);
        frame(0, 1, 8'h2c, 8'h07, 0, 2'd3, 0, 0);
        frame(0, 1, 8'h2c, 8'h07, 0, 2'd3, 0, 0);
        frame(0, 1, 8'h2c, 8'h2c, 1, 2'd3, 0, 0);
        frame(0, 1, 8'h04, 8'h00, 0, 2'd3, 0, 0);
        frame(0, 1, 8'h04, 8'h00, 0, 2'd3, 0, 0);
        frame(0, 1, 8'h04, 8'h04, 0, 2'd3, 0, 0);
        frame(0, 0, 8'h00, 8'h04, 0, 2'd3, 0, 0);
        frame(0, 0, 8'h00, 8'h04, 0, 2'd3, 0, 0);
        frame(0, 0, 8'h00, 8'h00, 0, 2'd3, 0, 0);

        // Start pulse, reset right after it, start must re-qualify
        frame(0, 1, 8'h28, 8'h00, 0, 2'd3, 0, 0);
        frame(0, 1, 8'h28, 8'h00, 0, 2'd3, 0, 0);
        frame(0, 1, 8'h28, 8'h28, 1, 2'd3, 0, 0);
        frame(1, 1, 8'h28, 8'h00, 0, 2'd1, 1, 0);
        frame(0, 1, 8'h28, 8'h00, 0, 2'd1, 0, 0);
        frame(0, 1, 8'h28, 8'h00, 0, 2'd1, 0, 0);
        frame(0, 1, 8'h28, 8'h28, 1, 2'd1, 0, 0);
        for (int j = 1; j <= 3; j++) frame(0, 0, 8'h00, 8'h00, 0, 2'd1, 0, 0);

        // Long hold: held_frames saturates at 255
        for (int j = 1; j <= 262; j++)
            frame(0, 1, 8'h07, (j < 3) ? 8'h00 : 8'h07, 0, 2'd1, 1,
                  (j < 3) ? j : ((j - 3 > 255) ? 255 : j - 3));

        repeat (3) @(posedge frame_clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d expected=0 pending entries", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
